controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_if.sv | 30 +++
 rtl/controller.sv | 129 ++++++++++++
 tb/tb_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
// Bus between the single-cycle-datapath controller and its datapath/ROM.
// The master side is the controller; the slave side is the datapath (or a bench).
interface controller_if;
   logic        V;
   logic        C;
   logic        N;
   logic        Z;
   logic [15:0] bus_A;
   logic [15:0] ROM_data;
   logic        MD;
   logic        RW;
   logic        MW;
   logic [1:0]  MB;
   logic [3:0]  FS;
   logic [3:0]  DR;
   logic [3:0]  SA;
   logic [3:0]  SB;
   logic [5:0]  PC;
   logic [15:0] imdt;

   modport master (
      input  V, C, N, Z, bus_A, ROM_data,
      output MD, RW, MW, MB, FS, DR, SA, SB, PC, imdt
   );

   modport slave (
      output V, C, N, Z, bus_A, ROM_data,
      input  MD, RW, MW, MB, FS, DR, SA, SB, PC, imdt
   );
endinterface

// File: rtl/controller.sv
// Two-phase (FETCH/EXEC) instruction controller with HALT: holds IR and PC,
// decodes the opcode into datapath controls and resolves branches/jumps.
module controller (
   input  logic         clk,
   input  logic         rst,
   controller_if.master bus
);
   localparam int unsigned IW = 16;
   localparam int unsigned PW = 6;

   localparam logic [3:0] OP_MOV = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_INC = 4'h7;
   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_LD  = 4'h9;
   localparam logic [3:0] OP_ST  = 4'hA;
   localparam logic [3:0] OP_SHR = 4'hB;
   localparam logic [3:0] OP_BRZ = 4'hC;
   localparam logic [3:0] OP_BRN = 4'hD;
   localparam logic [3:0] OP_JMP = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ir_q, ir_d;
   logic [PW-1:0] pc_q, pc_d;

   logic [3:0]    opcode;
   logic [PW-1:0] br_off;
   logic [PW-1:0] pc_inc;

   logic          md_c;
   logic          rw_c;
   logic          mw_c;
   logic [1:0]    mb_c;
   logic [3:0]    fs_c;

   // V, C and the upper A-bus bits have no consumer in this instruction set
   logic          unused_inputs;
   assign unused_inputs = ^{bus.V, bus.C, bus.bus_A[IW-1:PW]};

   assign opcode = ir_q[15:12];
   // 6-bit two's-complement offset; modulo-64 add performs the sign extension
   assign br_off = {ir_q[9:8], ir_q[3:0]};
   assign pc_inc = pc_q + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         ir_q    <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      case (state_q)
         FETCH: begin
            ir_d    = bus.ROM_data;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            case (opcode)
               OP_BRZ:  pc_d = bus.Z ? (pc_q + br_off) : pc_inc;
               OP_BRN:  pc_d = bus.N ? (pc_q + br_off) : pc_inc;
               OP_JMP:  pc_d = bus.bus_A[PW-1:0];
               OP_HLT:  state_d = HALT;
               default: pc_d = pc_inc;
            endcase
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // Datapath controls are live only while an instruction executes
   always_comb begin
      md_c = 1'b0;
      rw_c = 1'b0;
      mw_c = 1'b0;
      mb_c = 2'b00;
      fs_c = 4'b0000;
      if (state_q == EXEC) begin
         case (opcode)
            OP_MOV: rw_c = 1'b1;
            OP_ADD: begin rw_c = 1'b1; fs_c = 4'b0010; end
            OP_SUB: begin rw_c = 1'b1; fs_c = 4'b0101; end
            OP_AND: begin rw_c = 1'b1; fs_c = 4'b1000; end
            OP_OR:  begin rw_c = 1'b1; fs_c = 4'b1001; end
            OP_XOR: begin rw_c = 1'b1; fs_c = 4'b1010; end
            OP_NOT: begin rw_c = 1'b1; fs_c = 4'b1011; end
            OP_INC: begin rw_c = 1'b1; fs_c = 4'b0001; end
            OP_LDI: begin rw_c = 1'b1; mb_c = 2'b01; fs_c = 4'b1100; end
            OP_LD:  begin rw_c = 1'b1; md_c = 1'b1; end
            OP_ST:  mw_c = 1'b1;
            OP_SHR: begin rw_c = 1'b1; fs_c = 4'b1101; end
            default: ;
         endcase
      end
   end

   assign bus.MD   = md_c;
   assign bus.RW   = rw_c;
   assign bus.MW   = mw_c;
   assign bus.MB   = mb_c;
   assign bus.FS   = fs_c;
   assign bus.DR   = ir_q[11:8];
   assign bus.SA   = ir_q[7:4];
   assign bus.SB   = ir_q[3:0];
   assign bus.PC   = pc_q;
   assign bus.imdt = {12'b0, ir_q[3:0]};
endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected EXEC controls and next PC are
// queued when an instruction is presented and checked as the DUT executes it.
module tb_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;

   controller_if ifc ();

   controller dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        md;
      logic        rw;
      logic        mw;
      logic [1:0]  mb;
      logic [3:0]  fs;
      logic [3:0]  dr;
      logic [3:0]  sa;
      logic [3:0]  sb;
      logic [15:0] imdt;
      logic [5:0]  pc_next;
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] exp_pc;
   int         checks = 0;
   int         errors = 0;

   function automatic exp_t model(input logic [15:0] ir, input logic [5:0] pc,
                                  input logic z, input logic n, input logic [15:0] a);
      exp_t       m;
      logic [5:0] off;
      m      = '0;
      m.dr   = ir[11:8];
      m.sa   = ir[7:4];
      m.sb   = ir[3:0];
      m.imdt = {12'h000, ir[3:0]};
      off    = {ir[9:8], ir[3:0]};
      case (ir[15:12])
         4'h0: m.rw = 1'b1;
         4'h1: begin m.rw = 1'b1; m.fs = 4'b0010; end
         4'h2: begin m.rw = 1'b1; m.fs = 4'b0101; end
         4'h3: begin m.rw = 1'b1; m.fs = 4'b1000; end
         4'h4: begin m.rw = 1'b1; m.fs = 4'b1001; end
         4'h5: begin m.rw = 1'b1; m.fs = 4'b1010; end
         4'h6: begin m.rw = 1'b1; m.fs = 4'b1011; end
         4'h7: begin m.rw = 1'b1; m.fs = 4'b0001; end
         4'h8: begin m.rw = 1'b1; m.mb = 2'b01; m.fs = 4'b1100; end
         4'h9: begin m.rw = 1'b1; m.md = 1'b1; end
         4'hA: m.mw = 1'b1;
         4'hB: begin m.rw = 1'b1; m.fs = 4'b1101; end
         default: ;
      endcase
      case (ir[15:12])
         4'hC:    m.pc_next = z ? 6'(pc + off) : 6'(pc + 6'd1);
         4'hD:    m.pc_next = n ? 6'(pc + off) : 6'(pc + 6'd1);
         4'hE:    m.pc_next = a[5:0];
         4'hF:    m.pc_next = pc;
         default: m.pc_next = 6'(pc + 6'd1);
      endcase
      return m;
   endfunction

   // Assert reset at a negedge, check asynchronous clear, release at next negedge
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS, ifc.DR, ifc.SA, ifc.SB, ifc.PC, ifc.imdt} !== '0) begin
         errors++;
         $display("FAIL %s reset_outputs md=%b rw=%b mw=%b mb=%b fs=%h dr=%h sa=%h sb=%h pc=%h imdt=%h want all 0",
                  tag, ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS, ifc.DR, ifc.SA, ifc.SB, ifc.PC, ifc.imdt);
      end
      @(negedge clk);
      rst    = 1'b0;
      exp_pc = 6'd0;
   endtask

   // Entered at a negedge in FETCH; leaves at a negedge after the EXEC edge
   task automatic exec_one(input logic [15:0] instr, input logic z, input logic n,
                           input logic [15:0] a, input string tag);
      exp_t e;
      checks++;
      if ({ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS} !== 9'd0) begin
         errors++;
         $display("FAIL %s fetch_ctrl md=%b rw=%b mw=%b mb=%b fs=%b want all 0",
                  tag, ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS);
      end
      checks++;
      if (ifc.PC !== exp_pc) begin
         errors++;
         $display("FAIL %s fetch_pc got %0d want %0d", tag, ifc.PC, exp_pc);
      end
      ifc.ROM_data = instr;
      ifc.Z        = z;
      ifc.N        = n;
      ifc.V        = 1'($urandom);
      ifc.C        = 1'($urandom);
      ifc.bus_A    = a;
      exp_q.push_back(model(instr, exp_pc, z, n, a));
      @(posedge clk);
      @(negedge clk);
      ifc.ROM_data = 16'($urandom);
      e = exp_q.pop_front();
      checks++;
      if ({ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS} !== {e.md, e.rw, e.mw, e.mb, e.fs}) begin
         errors++;
         $display("FAIL %s exec_ctrl ir=%h got md=%b rw=%b mw=%b mb=%b fs=%b want md=%b rw=%b mw=%b mb=%b fs=%b",
                  tag, instr, ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS, e.md, e.rw, e.mw, e.mb, e.fs);
      end
      checks++;
      if ({ifc.DR, ifc.SA, ifc.SB, ifc.imdt} !== {e.dr, e.sa, e.sb, e.imdt}) begin
         errors++;
         $display("FAIL %s exec_fields ir=%h got dr=%h sa=%h sb=%h imdt=%h want dr=%h sa=%h sb=%h imdt=%h",
                  tag, instr, ifc.DR, ifc.SA, ifc.SB, ifc.imdt, e.dr, e.sa, e.sb, e.imdt);
      end
      checks++;
      if (ifc.PC !== exp_pc) begin
         errors++;
         $display("FAIL %s exec_pc_hold got %0d want %0d", tag, ifc.PC, exp_pc);
      end
      @(posedge clk);
      @(negedge clk);
      exp_pc = e.pc_next;
      checks++;
      if (ifc.PC !== exp_pc) begin
         errors++;
         $display("FAIL %s next_pc ir=%h got %0d want %0d", tag, instr, ifc.PC, exp_pc);
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ifc.MD, ifc.RW, ifc.MW, ifc.MB, ifc.FS, ifc.DR, ifc.SA, ifc.SB, ifc.PC, ifc.imdt} !== '0) begin
         errors++;
         $display("FAIL power_on_reset outputs not all 0 pc=%h dr=%h fs=%h", ifc.PC, ifc.DR, ifc.FS);
      end
      rst    = 1'b0;
      exp_pc = 6'd0;
   endtask

   task automatic test_ldi();
      exec_one(16'h830D, 1'b0, 1'b0, 16'h0000, "ldi");
   endtask

   task automatic test_sub_add();
      do_reset("sub_add");
      exec_one(16'h230D, 1'b1, 1'b1, 16'hFFFF, "sub");
      exec_one(16'h130D, 1'b0, 1'b0, 16'h1234, "add");
   endtask

   task automatic test_branch();
      do_reset("brz_nt");
      exec_one(16'h0000, 1'b1, 1'b1, 16'h0000, "mov0");
      exec_one(16'h0000, 1'b1, 1'b1, 16'h0000, "mov1");
      exec_one(16'hC33D, 1'b0, 1'b1, 16'h003F, "brz_not_taken");
      do_reset("brz_t");
      exec_one(16'h0000, 1'b0, 1'b0, 16'h0000, "mov2");
      exec_one(16'h0000, 1'b0, 1'b0, 16'h0000, "mov3");
      exec_one(16'hC33D, 1'b1, 1'b0, 16'h0000, "brz_taken");
      exec_one(16'h7100, 1'b0, 1'b0, 16'h0000, "inc_wrap");
      exec_one(16'hD105, 1'b0, 1'b1, 16'h0000, "brn_taken");
      exec_one(16'hD1F5, 1'b1, 1'b0, 16'h0000, "brn_not_taken");
   endtask

   task automatic test_jmp();
      exec_one(16'hE030, 1'b0, 1'b0, 16'h0025, "jmp");
      exec_one(16'hE000, 1'b1, 1'b1, 16'hFFC3, "jmp_hi_bits");
   endtask

   task automatic test_st_ld();
      exec_one(16'hA012, 1'b0, 1'b0, 16'h0000, "st");
      exec_one(16'h9120, 1'b0, 1'b0, 16'h0000, "ld");
   endtask

   task automatic test_halt();
      exec_one(16'hFF3D, 1'b1, 1'b1, 16'h0011, "hlt");
      for (int i = 0; i < 10; i++) begin
         ifc.ROM_data = 16'h830D;
         ifc.Z        = 1'($urandom);
         ifc.N        = 1'($urandom);
         ifc.bus_A    = 16'($urandom);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (ifc.PC !== exp_pc || {ifc.RW, ifc.MW, ifc.MD, ifc.MB, ifc.FS} !== 9'd0) begin
            errors++;
            $display("FAIL halt_hold cycle %0d pc=%0d rw=%b mw=%b fs=%b want pc=%0d controls 0",
                     i, ifc.PC, ifc.RW, ifc.MW, ifc.FS, exp_pc);
         end
      end
      do_reset("halt_exit");
      exec_one(16'h830D, 1'b0, 1'b0, 16'h0000, "after_halt");
   endtask

   task automatic test_reset_mid_exec();
      exec_one(16'h0000, 1'b0, 1'b0, 16'h0000, "pre_abort");
      ifc.ROM_data = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (ifc.PC !== 6'd0 || ifc.RW !== 1'b0 || ifc.DR !== 4'd0 || ifc.FS !== 4'd0) begin
         errors++;
         $display("FAIL abort_exec pc=%0d rw=%b dr=%h fs=%b want all 0", ifc.PC, ifc.RW, ifc.DR, ifc.FS);
      end
      @(negedge clk);
      rst    = 1'b0;
      exp_pc = 6'd0;
      exec_one(16'h530D, 1'b0, 1'b0, 16'h0000, "after_abort");
   endtask

   task automatic test_back_to_back();
      logic [15:0] instr;
      for (int i = 0; i < 30; i++) begin
         instr = {4'($urandom_range(0, 14)), 12'($urandom)};
         exec_one(instr, 1'($urandom), 1'($urandom), 16'($urandom), "b2b");
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      ifc.ROM_data = 16'h830D;
      ifc.V        = 1'b0;
      ifc.C        = 1'b0;
      ifc.N        = 1'b0;
      ifc.Z        = 1'b0;
      ifc.bus_A    = 16'h0000;
      exp_pc       = 6'd0;
      test_reset();
      test_ldi();
      test_sub_add();
      test_branch();
      test_jmp();
      test_st_ld();
      test_reset_mid_exec();
      test_back_to_back();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
